// File: rtl/truncation_stim_checker_if.sv
// Stimulus and response handshake bundle between the checker and the device under test.
interface truncation_stim_checker_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8
);
  logic             stim_valid;
  logic             stim_ready;
  logic [IN_W-1:0]  stim_bits;
  logic             resp_valid;
  logic             resp_ready;
  logic [OUT_W-1:0] resp_bits;

  modport master (
    output stim_valid, stim_bits, resp_ready,
    input  stim_ready, resp_valid, resp_bits
  );

  modport slave (
    input  stim_valid, stim_bits, resp_ready,
    output stim_ready, resp_valid, resp_bits
  );
endinterface

// File: rtl/truncation_stim_checker.sv
// LFSR stimulus generator checking that each response equals the low OUT_W bits of its stimulus.
// One vector in flight; 2 cycles per vector minimum; stalls on stim_ready, times out on a silent DUT.
module truncation_stim_checker #(
  parameter int          IN_W        = 16,
  parameter int          OUT_W       = 8,
  parameter int          NUM_VECTORS = 64,
  parameter int          TIMEOUT     = 255,
  parameter logic [31:0] SEED        = 32'h0000_ACE1,
  parameter logic [31:0] TAPS        = 32'h0000_B400
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  truncation_stim_checker_if.master     bus,
  output logic                          done,
  output logic                          pass,
  output logic                          timeout,
  output logic [7:0]                    err_count,
  output logic [15:0]                   vec_count
);

  localparam logic [IN_W-1:0] SEED_W = SEED[IN_W-1:0];
  localparam logic [IN_W-1:0] TAPS_W = TAPS[IN_W-1:0];
  localparam logic [15:0]     NV_L   = 16'(NUM_VECTORS);
  localparam logic [15:0]     TMO_L  = 16'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [IN_W-1:0]  lfsr_q, lfsr_d;
  logic [OUT_W-1:0] exp_q, exp_d;
  logic [15:0]      timer_q, timer_d;
  logic [7:0]       err_q, err_d;
  logic [15:0]      vec_q, vec_d;
  logic             tmo_q, tmo_d;
  logic [IN_W-1:0]  lfsr_step;

  assign lfsr_step = {1'b0, lfsr_q[IN_W-1:1]} ^ (lfsr_q[0] ? TAPS_W : '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED_W;
      exp_q   <= '0;
      timer_q <= '0;
      err_q   <= '0;
      vec_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      exp_q   <= exp_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      vec_q   <= vec_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    exp_d   = exp_q;
    timer_d = timer_q;
    err_d   = err_q;
    vec_d   = vec_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SEND;
          lfsr_d  = SEED_W;
          err_d   = '0;
          vec_d   = '0;
          tmo_d   = 1'b0;
        end
      end
      S_SEND: begin
        if (bus.stim_ready) begin
          exp_d   = lfsr_q[OUT_W-1:0];
          lfsr_d  = lfsr_step;
          timer_d = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response on the limit cycle takes priority over the timeout.
        if (bus.resp_valid) begin
          if (bus.resp_bits != exp_q && err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
          end
          vec_d   = vec_q + 16'd1;
          state_d = (vec_q + 16'd1 == NV_L) ? S_DONE : S_SEND;
        end else if (timer_q == TMO_L) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.stim_valid = (state_q == S_SEND);
  assign bus.stim_bits  = (state_q == S_SEND) ? lfsr_q : '0;
  assign bus.resp_ready = (state_q == S_WAIT);
  assign done           = (state_q == S_DONE);
  assign pass           = (state_q == S_DONE) && (err_q == 8'd0) && !tmo_q;
  assign timeout        = tmo_q;
  assign err_count      = err_q;
  assign vec_count      = vec_q;

endmodule

// File: doc/truncation_stim_checker.md
# truncation_stim_checker

Self-checking stimulus generator and response checker for width-truncation tests. It feeds pseudo-random IN_W-bit vectors to a device under test through a valid/ready handshake and collects the DUT's OUT_W-bit responses. Each response is checked against the low OUT_W bits of the vector that produced it. It reports completion, pass/fail and an error count, which the simulation harness uses directly as its stop condition.

## Interface
- IN_W, 16, stimulus width (2..32).
- OUT_W, 8, response width; 1 ≤ OUT_W ≤ IN_W.
- NUM_VECTORS, 64, vectors per run (1..65535).
- TIMEOUT, 255, maximum WAIT cycles per vector (1..65535).
- SEED, 16'hACE1, LFSR seed, zero-extended or truncated to IN_W; must be nonzero in the low IN_W bits.
- TAPS, 16'hB400, Galois LFSR feedback mask, zero-extended or truncated to IN_W.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; one clock, no other clock domains.
- start  in  1  begin a run; sampled only in IDLE and DONE.
- stim_valid  out  1  stimulus valid.
- stim_ready  in  1  DUT accepts stimulus.
- stim_bits  out  IN_W  stimulus value.
- resp_valid  in  1  DUT response valid.
- resp_ready  out  1  checker accepts response.
- resp_bits  in  OUT_W  DUT response.
- done  out  1  run finished; held until restart or reset.
- pass  out  1  valid only while done=1; 1 iff err_count==0 and timeout==0.
- timeout  out  1  a response wait exceeded TIMEOUT.
- err_count  out  8  mismatch count; saturates at 255.
- vec_count  out  16  number of vectors checked in the current run.

## Operation
- States:
  - IDLE (reset state).
  - SEND.
  - WAIT.
  - DONE.
- Reset values:
  - All outputs are 0.
  - The LFSR register is set to SEED.
  - The wait timer is 0.
- IDLE: while start=1, go to SEND. On entry to SEND:
  - err_count, vec_count and timeout are cleared.
  - The LFSR is reloaded with SEED.
- SEND:
  - stim_valid=1 and stim_bits=LFSR.
  - stim_bits is held stable until stim_valid and stim_ready are both 1 on a rising edge.
  - On that handshake:
    - The accepted value's low OUT_W bits are latched into an expected register.
    - The LFSR advances.
    - The wait timer clears.
    - The state goes to WAIT.
- LFSR step (Galois, right shift): next = (cur >> 1) ^ (cur[0] ? TAPS : 0).
- WAIT:
  - resp_ready=1.
  - resp_valid=1 completes the vector:
    - If resp_bits != expected, err_count increments (saturating).
    - vec_count increments.
    - If the new vec_count equals NUM_VECTORS, go to DONE; otherwise go to SEND.
  - If no response arrives, the timer increments each cycle. When it reaches TIMEOUT with resp_valid=0:
    - timeout is set to 1.
    - The state goes to DONE.
    - vec_count does not change.
  - If the response and the timer limit occur on the same cycle, the response wins and timeout stays 0.
- DONE:
  - done=1 and pass is computed as defined under Interface.
  - stim_valid=0 and resp_ready=0.
  - start=1 restarts the run exactly as from IDLE.
  - done falls on the cycle SEND is entered.
- resp_valid is ignored outside WAIT. stim_ready is ignored outside SEND.
- Asynchronous reset in any state returns the block to IDLE immediately with the reset values listed above. No partial run is reported.

## Timing
- start to first stim_valid: 1 cycle (registered state).
- Stimulus handshake to resp_ready=1: 1 cycle.
- Response accepted to next stim_valid: 1 cycle.
- Back-to-back minimum: 2 cycles per vector when the DUT responds with 0 latency.
- Final response to done=1: 1 cycle. err_count, vec_count and pass are already final on that cycle.
- Timeout: done rises TIMEOUT+1 cycles after WAIT is entered.
- All outputs are registered or decoded directly from state. There is no combinational path from any input to any output.

## Test plan
- Sequence check, default parameters, start pulse, DUT stalled (stim_ready=0):
  - First stim_bits=0xACE1.
  - Accept it; the second stimulus is 0xE270.
  - Expected responses are 0xE1 then 0x70.
- Loopback DUT returning stim_bits[7:0] after 1 cycle, 64 vectors:
  - done=1, pass=1, err_count=0, vec_count=64, timeout=0.
  - No second run starts without a new start pulse.
- Same loopback with vector 5's response bit 0 flipped:
  - err_count=1, pass=0, vec_count=64.
- Hold stim_ready=0 for 10 cycles in SEND:
  - stim_valid stays 1 and stim_bits stays constant.
  - The LFSR does not advance.
  - On acceptance, the following value is the next LFSR step.
- DUT never asserts resp_valid:
  - done rises 256 cycles after WAIT is entered.
  - timeout=1, pass=0, vec_count=0.
  - resp_valid=1 on exactly the 255th WAIT cycle instead yields no timeout.
- Assert reset during vector 30:
  - All outputs go to 0 immediately.
  - A new start reruns from 0xACE1 with the counters cleared.
